sal_rd_resp: RTL and testbench

- Read-return path of the DDR2 controller, opposite direction to the AXI-AR-to-DFI command path.
- Scheduler posts a read tag (AXI ID, burst length) when a column read is accepted for issue.
- Block captures returning DFI read data beats, pairs them in order with tags, and drives the AXI R channel with RLAST.
- Reserves buffer space at issue time; DFI read data has no backpressure.

---
 rtl/sal_rd_resp.sv | 120 ++++++++++++
 tb/tb_sal_rd_resp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sal_rd_resp.sv
// rtl/sal_rd_resp.sv - DDR2 read-return path: pairs DFI read beats with issued tags and drives AXI R.
// Buffer space is reserved at tag issue so DFI read data never needs backpressure.
module sal_rd_resp #(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 4,
  parameter int TAG_DEPTH  = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_issue_valid,
  output logic              rd_issue_ready,
  input  logic [ID_W-1:0]   rd_issue_id,
  input  logic [LEN_W-1:0]  rd_issue_len,
  input  logic              dfi_rddata_valid,
  input  logic [DATA_W-1:0] dfi_rddata,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              unexp_err
);

  localparam int TA_W  = $clog2(TAG_DEPTH);
  localparam int DA_W  = $clog2(DATA_DEPTH);
  localparam int RES_W = $clog2(DATA_DEPTH + 1);
  localparam int CMP_W = RES_W + 1;

  logic [ID_W-1:0]   tag_id_mem  [TAG_DEPTH];
  logic [LEN_W-1:0]  tag_len_mem [TAG_DEPTH];
  logic [DATA_W-1:0] data_mem    [DATA_DEPTH];

  logic [TA_W:0]      tag_wr, tag_rd;
  logic [DA_W:0]      data_wr, data_rd;
  logic [RES_W-1:0]   reserved;
  logic [LEN_W-1:0]   beat_cnt;

  logic               tag_full, tag_empty, data_empty;
  logic [DA_W:0]      data_occ;
  logic [RES_W-1:0]   expected;
  logic               issue_fire, r_fire, dfi_wr, dfi_drop;
  logic [ID_W-1:0]    head_id;
  logic [LEN_W-1:0]   head_len;
  logic [RES_W-1:0]   res_add, res_sub;

  assign tag_empty  = (tag_wr == tag_rd);
  assign tag_full   = (tag_wr[TA_W] != tag_rd[TA_W]) &&
                      (tag_wr[TA_W-1:0] == tag_rd[TA_W-1:0]);
  assign data_empty = (data_wr == data_rd);
  assign data_occ   = data_wr - data_rd;

  // Beats promised to tags that the DFI has not delivered yet.
  assign expected = reserved - RES_W'(data_occ);

  assign rd_issue_ready = !tag_full &&
                          ((CMP_W'(reserved) + CMP_W'(rd_issue_len) + CMP_W'(1)) <= CMP_W'(DATA_DEPTH));
  assign issue_fire     = rd_issue_valid && rd_issue_ready;

  assign dfi_wr   = dfi_rddata_valid && (expected != '0);
  assign dfi_drop = dfi_rddata_valid && (expected == '0);

  assign head_id  = tag_id_mem[tag_rd[TA_W-1:0]];
  assign head_len = tag_len_mem[tag_rd[TA_W-1:0]];

  assign rvalid = !tag_empty && !data_empty;
  assign rid    = rvalid ? head_id : '0;
  assign rdata  = rvalid ? data_mem[data_rd[DA_W-1:0]] : '0;
  assign rlast  = rvalid && (beat_cnt == head_len);
  assign rresp  = 2'b00;
  assign r_fire = rvalid && rready;

  assign res_add = issue_fire ? (RES_W'(rd_issue_len) + RES_W'(1)) : '0;
  assign res_sub = r_fire ? RES_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      tag_id_mem[tag_wr[TA_W-1:0]]  <= rd_issue_id;
      tag_len_mem[tag_wr[TA_W-1:0]] <= rd_issue_len;
    end
    if (dfi_wr) begin
      data_mem[data_wr[DA_W-1:0]] <= dfi_rddata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr    <= '0;
      tag_rd    <= '0;
      data_wr   <= '0;
      data_rd   <= '0;
      reserved  <= '0;
      beat_cnt  <= '0;
      unexp_err <= 1'b0;
    end else begin
      if (issue_fire) begin
        tag_wr <= tag_wr + 1'b1;
      end
      if (dfi_wr) begin
        data_wr <= data_wr + 1'b1;
      end
      if (dfi_drop) begin
        unexp_err <= 1'b1;
      end
      reserved <= reserved + res_add - res_sub;
      if (r_fire) begin
        data_rd <= data_rd + 1'b1;
        if (rlast) begin
          tag_rd   <= tag_rd + 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sal_rd_resp.sv
// tb/tb_sal_rd_resp.sv - directed plus randomized bench for sal_rd_resp against a queue-based reference.
module tb_sal_rd_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_issue_valid;
  logic        rd_issue_ready;
  logic [3:0]  rd_issue_id;
  logic [3:0]  rd_issue_len;
  logic        dfi_rddata_valid;
  logic [63:0] dfi_rddata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        unexp_err;

  always #5 clk = ~clk;

  sal_rd_resp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_issue_valid   (rd_issue_valid),
    .rd_issue_ready   (rd_issue_ready),
    .rd_issue_id      (rd_issue_id),
    .rd_issue_len     (rd_issue_len),
    .dfi_rddata_valid (dfi_rddata_valid),
    .dfi_rddata       (dfi_rddata),
    .rvalid           (rvalid),
    .rready           (rready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .unexp_err        (unexp_err)
  );

  typedef struct {
    logic [3:0] id;
    logic [3:0] len;
  } tag_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  tag_t        tag_q[$];
  logic [63:0] data_q[$];
  int          head_popped;
  bit          unexp_m;

  // Beats owed to outstanding tags, minus those already handed out on R.
  function automatic int m_reserved();
    int s = 0;
    foreach (tag_q[i]) s += int'(tag_q[i].len) + 1;
    return s - head_popped;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    tag_q.delete();
    data_q.delete();
    head_popped = 0;
    unexp_m = 1'b0;
  endtask

  task automatic cycle(input bit iv, input logic [3:0] id, input logic [3:0] len,
                       input bit dv, input logic [63:0] d, input bit rr);
    bit   exp_ready, exp_rv, exp_last;
    int   owed;
    tag_t t;
    @(negedge clk);
    rd_issue_valid   = iv;
    rd_issue_id      = id;
    rd_issue_len     = len;
    dfi_rddata_valid = dv;
    dfi_rddata       = d;
    rready           = rr;
    #1;
    exp_ready = (tag_q.size() < 8) && (m_reserved() + int'(len) + 1 <= 16);
    exp_rv    = (tag_q.size() > 0) && (data_q.size() > 0);
    owed      = m_reserved() - data_q.size();
    chk("rd_issue_ready", 64'(rd_issue_ready), 64'(exp_ready));
    chk("rvalid", 64'(rvalid), 64'(exp_rv));
    chk("rresp", 64'(rresp), 64'd0);
    chk("unexp_err", 64'(unexp_err), 64'(unexp_m));
    exp_last = 1'b0;
    if (exp_rv) begin
      exp_last = (head_popped == int'(tag_q[0].len));
      chk("rid", 64'(rid), 64'(tag_q[0].id));
      chk("rdata", rdata, data_q[0]);
      chk("rlast", 64'(rlast), 64'(exp_last));
    end
    @(posedge clk);
    if (iv && exp_ready) begin
      t.id  = id;
      t.len = len;
      tag_q.push_back(t);
    end
    if (dv) begin
      if (owed > 0) data_q.push_back(d);
      else          unexp_m = 1'b1;
    end
    if (exp_rv && rr) begin
      void'(data_q.pop_front());
      if (exp_last) begin
        void'(tag_q.pop_front());
        head_popped = 0;
      end else begin
        head_popped++;
      end
    end
  endtask

  task automatic idle(input bit rr);
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 64'd0, rr);
  endtask

  task automatic beat(input logic [63:0] d, input bit rr);
    cycle(1'b0, 4'd0, 4'd0, 1'b1, d, rr);
  endtask

  task automatic issue(input logic [3:0] id, input logic [3:0] len);
    cycle(1'b1, id, len, 1'b0, 64'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    rd_issue_valid   = 1'b0;
    rd_issue_len     = 4'd15;
    dfi_rddata_valid = 1'b0;
    rready           = 1'b0;
    #1;
    model_clear();
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_unexp_err", 64'(unexp_err), 64'd0);
    chk("rst_ready_len15", 64'(rd_issue_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    rd_issue_valid   = 1'b0;
    rd_issue_id      = 4'd0;
    rd_issue_len     = 4'd0;
    dfi_rddata_valid = 1'b0;
    dfi_rddata       = 64'd0;
    rready           = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    pulse_reset();

    // Single beat transfer
    issue(4'd3, 4'd0);
    beat(64'hA5A5, 1'b0);
    idle(1'b1);
    cycle(1'b1, 4'd0, 4'd15, 1'b0, 64'd0, 1'b0);
    repeat (16) beat({$urandom, $urandom}, 1'b1);
    repeat (3) idle(1'b1);

    // Burst with a 3-cycle R stall
    issue(4'd1, 4'd3);
    beat(64'h1111, 1'b0);
    beat(64'h2222, 1'b0);
    beat(64'h3333, 1'b0);
    beat(64'h4444, 1'b0);
    repeat (3) idle(1'b0);
    repeat (5) idle(1'b1);

    // Backpressure on reserved beats
    issue(4'd2, 4'd15);
    cycle(1'b1, 4'd5, 4'd0, 1'b0, 64'd0, 1'b0);
    beat(64'hBEEF, 1'b0);
    idle(1'b1);
    cycle(1'b1, 4'd5, 4'd0, 1'b0, 64'd0, 1'b0);
    repeat (15) beat({$urandom, $urandom}, 1'b1);
    repeat (4) idle(1'b1);

    // Tag FIFO full
    for (int i = 0; i < 8; i++) issue(4'(i), 4'd0);
    cycle(1'b1, 4'd9, 4'd0, 1'b0, 64'd0, 1'b0);
    beat(64'hC0DE, 1'b0);
    idle(1'b1);
    cycle(1'b1, 4'd9, 4'd0, 1'b0, 64'd0, 1'b0);
    repeat (8) beat({$urandom, $urandom}, 1'b1);
    repeat (3) idle(1'b1);

    // Unexpected data with nothing outstanding
    beat(64'hDEAD, 1'b1);
    repeat (3) idle(1'b1);

    // Reset mid-burst after two of four beats popped
    issue(4'd6, 4'd3);
    for (int i = 0; i < 4; i++) beat(64'(100 + i), 1'b0);
    idle(1'b1);
    idle(1'b1);
    pulse_reset();
    repeat (2) idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 6), {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
    end
    repeat (40) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
